// File: rtl/regfile_sb_pkg.sv
// Shared CPU definitions: default datapath sizes, register-address type and the hardwired zero register.
package regfile_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_sb_bypass.sv
// Per-read-port bypass: picks the highest-indexed write that matches the read address, else stored data.
// Purely combinational, no backpressure; a write hit also masks the stored busy bit.
module regfile_sb_bypass
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int NWR  = 1
) (
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     stored_data_i,
    input  logic                stored_busy_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                rd_busy_o
);

    logic [XLEN-1:0] data_sel;
    logic            wr_hit;
    logic            is_zero;

    assign is_zero = (rd_addr_i == AW'(ZERO_REG));

    // Ascending scan so the last (highest-indexed) matching port overrides earlier ones.
    always_comb begin
        data_sel = stored_data_i;
        wr_hit   = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                data_sel = wr_data_i[j*XLEN +: XLEN];
                wr_hit   = 1'b1;
            end
        end
    end

    assign rd_data_o = is_zero ? '0 : data_sel;
    assign rd_busy_o = ~is_zero & stored_busy_i & ~wr_hit;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and a pending-write scoreboard; x0 hardwired to zero.
// Reads combinational, writes/issue/flush commit on the next edge; no backpressure.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NWR-1:0]  wr_en_eff;

    // Reset and x0 are folded into the strobes, so neither commit nor bypass ever sees them.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wr_en_eff[j] = wr_en[j] & rst_n & (wr_addr[j*AW +: AW] != AW'(ZERO_REG));
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_eff[j]) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Clear on writeback, then set on issue (back-to-back producers), then flush overrides all.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_eff[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && (iss_rd != AW'(ZERO_REG))) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[i*AW +: AW];

        regfile_sb_bypass #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_bypass (
            .rd_addr_i     (ra),
            .stored_data_i (regs_q[ra]),
            .stored_busy_i (busy_q[ra]),
            .wr_en_i       (wr_en_eff),
            .wr_addr_i     (wr_addr),
            .wr_data_i     (wr_data),
            .rd_data_o     (rd_data[i*XLEN +: XLEN]),
            .rd_busy_o     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb with two read and two write ports.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        iv;
        logic [4:0]  ir;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] ebv;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1, input logic iv,
                          input logic [4:0] ir, input logic fl, input logic [4:0] r0,
                          input logic [4:0] r1);
        wr_en     = we;
        wr_addr   = {a1, a0};
        wr_data   = {d1, d0};
        iss_valid = iv;
        iss_rd    = ir;
        flush     = fl;
        rd_addr   = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1);
    endtask

    // Reference: registers as an array, pending bits as a vector, updated per clock by the architectural rules.
    task automatic cycle();
        logic [31:0] nr [32];
        logic [31:0] nb;
        nr = m_regs;
        nb = m_busy;
        for (int j = 0; j < 2; j++) begin
            logic [4:0] a;
            a = wr_addr[j*5 +: 5];
            if (wr_en[j] && a != 5'd0) begin
                nr[a] = wr_data[j*32 +: 32];
                nb[a] = 1'b0;
            end
        end
        if (iss_valid && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
        if (flush) nb = '0;
        @(posedge clk);
        m_regs = nr;
        m_busy = nb;
        #1;
    endtask

    function automatic logic write_hits(input logic [4:0] a);
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input int i);
        logic [4:0] a;
        a = rd_addr[i*5 +: 5];
        if (a == 5'd0) return 32'd0;
        for (int j = 1; j >= 0; j--)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) return wr_data[j*32 +: 32];
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int i);
        logic [4:0] a;
        a = rd_addr[i*5 +: 5];
        return (a != 5'd0) && m_busy[a] && !write_hits(a);
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;

        tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0,
                   32'hDEADBEEF, 32'd0, 2'b00, 32'h0};
        tbl[1] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5,
                   32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0};
        tbl[2] = '{2'b01, 5'd0, 32'h12345678, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd5,
                   32'd0, 32'hDEADBEEF, 2'b00, 32'h0};
        tbl[3] = '{2'b11, 5'd3, 32'h1, 5'd3, 32'h2, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3,
                   32'h2, 32'h2, 2'b00, 32'h0};
        tbl[4] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0,
                   32'h2, 32'd0, 2'b00, 32'h0};
        tbl[5] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0,
                   32'd0, 32'd0, 2'b00, 32'h1000};
        tbl[6] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd12,
                   32'd0, 32'd0, 2'b11, 32'h1000};
        tbl[7] = '{2'b10, 5'd0, 32'd0, 5'd12, 32'hCAFE, 1'b0, 5'd0, 1'b0, 5'd12, 5'd5,
                   32'hCAFE, 32'hDEADBEEF, 2'b00, 32'h0};
        tbl[8] = '{2'b11, 5'd4, 32'h44, 5'd6, 32'h66, 1'b1, 5'd4, 1'b0, 5'd4, 5'd6,
                   32'h44, 32'h66, 2'b00, 32'h10};
        tbl[9] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b1, 5'd4, 5'd8,
                   32'h44, 32'd0, 2'b01, 32'h0};

        // Reset state, and inputs ignored while held in reset
        rst_n = 1'b0;
        set_in(2'b01, 5'd5, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
        #2;
        chk("reset_busy_vec", busy_vec, 32'h0);
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_busy", rd_busy, 2'b00);
        @(posedge clk); #1;
        chk("reset_edge_busy_vec", busy_vec, 32'h0);
        chk("reset_edge_rd_data", rd_data, 64'h0);
        idle(5'd5, 5'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_reg5", rd_data[31:0], 32'h0);

        for (int v = 0; v < 10; v++) begin
            set_in(tbl[v].we, tbl[v].a0, tbl[v].d0, tbl[v].a1, tbl[v].d1,
                   tbl[v].iv, tbl[v].ir, tbl[v].fl, tbl[v].r0, tbl[v].r1);
            #1;
            chk($sformatf("tbl%0d_rd0", v), rd_data[31:0], tbl[v].e0);
            chk($sformatf("tbl%0d_rd1", v), rd_data[63:32], tbl[v].e1);
            chk($sformatf("tbl%0d_rbusy", v), rd_busy, tbl[v].eb);
            cycle();
            chk($sformatf("tbl%0d_bvec", v), busy_vec, tbl[v].ebv);
        end

        // Scoreboard: issue x7, writeback three cycles later
        set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        #1;
        chk("sb_issue_rbusy_pre", rd_busy[0], 1'b0);
        cycle();
        idle(5'd7, 5'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("sb_wait%0d_bvec7", k), busy_vec[7], 1'b1);
            chk($sformatf("sb_wait%0d_rbusy", k), rd_busy[0], 1'b1);
            cycle();
        end
        set_in(2'b01, 5'd7, 32'hA5, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        #1;
        chk("sb_wb_bvec7", busy_vec[7], 1'b1);
        chk("sb_wb_rbusy", rd_busy[0], 1'b0);
        chk("sb_wb_rd", rd_data[31:0], 32'hA5);
        cycle();
        idle(5'd7, 5'd0);
        #1;
        chk("sb_after_bvec7", busy_vec[7], 1'b0);
        chk("sb_after_rd", rd_data[31:0], 32'hA5);

        // Issue and writeback to the same register, then the same with flush
        set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
        cycle();
        set_in(2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
        #1;
        chk("sim_pre_bvec9", busy_vec[9], 1'b1);
        chk("sim_pre_rd", rd_data[31:0], 32'h99);
        chk("sim_pre_rbusy", rd_busy[0], 1'b0);
        cycle();
        idle(5'd9, 5'd0);
        #1;
        chk("sim_set_wins_bvec9", busy_vec[9], 1'b1);
        chk("sim_stored_rd", rd_data[31:0], 32'h99);
        set_in(2'b01, 5'd9, 32'h77, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd0);
        cycle();
        idle(5'd9, 5'd0);
        #1;
        chk("flush_bvec", busy_vec, 32'h0);
        chk("flush_write_rd", rd_data[31:0], 32'h77);

        // Mid-run asynchronous reset with a pending bit
        set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd5, 5'd9);
        cycle();
        idle(5'd10, 5'd9);
        #1;
        chk("pre_arst_bvec10", busy_vec[10], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_rd_data", rd_data, 64'h0);
        chk("arst_bvec", busy_vec, 32'h0);
        chk("arst_rbusy", rd_busy, 2'b00);
        set_in(2'b01, 5'd5, 32'h5555, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd7);
        #1;
        chk("arst_bypass_blocked", rd_data, 64'h0);
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        @(posedge clk); #1;
        idle(5'd5, 5'd7);
        rst_n = 1'b1;
        #1;
        chk("arst_release_rd", rd_data, 64'h0);
        chk("arst_release_bvec", busy_vec, 32'h0);

        // Randomised traffic against the reference
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra [4];
            for (int k = 0; k < 4; k++)
                ra[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            set_in(2'($urandom_range(0, 3)), ra[0], $urandom, ra[1], $urandom,
                   1'($urandom_range(0, 1)), ra[2], ($urandom_range(0, 15) == 0),
                   ra[3], 5'($urandom_range(0, 7)));
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd%0d_rd%0d", n, i), rd_data[i*32 +: 32], exp_rd(i));
                chk($sformatf("rnd%0d_rbusy%0d", n, i), rd_busy[i], exp_busy(i));
            end
            chk($sformatf("rnd%0d_bvec", n), busy_vec, m_busy);
            cycle();
        end
        idle(5'd0, 5'd0);
        #1;
        chk("final_bvec", busy_vec, m_busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, 32, data width per register.
REQ-002 SHALL have parameter NREG, 32, register count; power of two, at least 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, 2, number of read ports; at least 1.
REQ-004 SHALL have parameter NWR, 1, number of write ports; at least 1.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port rd_addr  in  NRD*AW  read addresses, port i at slice i.
REQ-008 SHALL have port rd_data  out  NRD*XLEN  read data, combinational.
REQ-009 SHALL have port rd_busy  out  NRD  scoreboard busy bit of each read address, combinational.
REQ-010 SHALL have port wr_en  in  NWR  write strobes.
REQ-011 SHALL have port wr_addr  in  NWR*AW  write addresses.
REQ-012 SHALL have port wr_data  in  NWR*XLEN  write data.
REQ-013 SHALL have port iss_valid  in  1  issue strobe; marks iss_rd pending.
REQ-014 SHALL have port iss_rd  in  AW  destination register being issued.
REQ-015 SHALL have port flush  in  1  clears all busy bits next edge; register contents untouched.
REQ-016 SHALL have port busy_vec  out  NREG  full scoreboard state, registered.

Function
REQ-017 SHALL hardwire register 0: reads return 0, rd_busy 0, writes and issues to address 0 ignored.
REQ-018 SHALL write wr_data[j] to wr_addr[j] on the edge where wr_en[j]=1; write latency one cycle.
REQ-019 SHALL, when multiple write ports target one address in the same cycle, commit the highest-indexed port.
REQ-020 SHALL bypass: a read whose address matches an enabled write in the same cycle returns that write data (highest-indexed matching port), otherwise the stored value.
REQ-021 SHALL set busy[iss_rd] on the edge where iss_valid=1 and iss_rd!=0.
REQ-022 SHALL clear busy[a] on the edge where any enabled write port targets a.
REQ-023 SHALL let set win over clear when issue and writeback hit the same register in the same cycle (back-to-back producers).
REQ-024 SHALL drive rd_busy[i] = busy[rd_addr[i]] AND NOT (any enabled write to rd_addr[i] this cycle); data and busy bypass are consistent.
REQ-025 SHALL give flush priority over issue: flush and iss_valid together leave all busy bits 0.
REQ-026 SHALL leave register writes unaffected by flush; writes in a flush cycle still commit.
REQ-027 SHALL treat out-of-range behaviour as impossible: every AW-bit address is valid, no wrap logic.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously clear all registers to 0 and all busy bits to 0.
REQ-029 SHALL hold busy_vec at 0 and rd_data at 0 for every port during reset; rd_busy at 0.
REQ-030 SHALL ignore wr_en and iss_valid while rst_n=0; first update on the first rising edge after release.
REQ-031 SHALL discard any in-flight scoreboard state when reset is asserted mid-operation; no pending bit survives.

Structure
REQ-032 SHALL take XLEN/NREG defaults, the register-address typedef and the zero-register constant from the shared cpu package.
REQ-033 SHALL use one sub-module, regfile_sb_bypass, implementing per-read-port write-match priority selection (data and busy bypass), instantiated NRD times.
REQ-034 SHALL keep the register array and busy vector verilator-public for C++ bench inspection.

Verification
REQ-035 SHALL check reset: drive rst_n=0 mid-run after writes -> all rd_data 0, busy_vec 0 immediately, without a clock edge.
REQ-036 SHALL check write/bypass: wr_en[0]=1, addr 5, data 0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF combinationally; next cycle stored value 0xDEADBEEF.
REQ-037 SHALL check x0: write 0x12345678 to 0 and issue rd=0 -> rd_data 0, busy_vec[0]=0.
REQ-038 SHALL check scoreboard: issue rd=7, then after 3 cycles write 7 with 0xA5 -> busy_vec[7]=1 for 3 cycles, rd_busy=0 and rd_data=0xA5 in the write cycle, busy 0 after.
REQ-039 SHALL check simultaneous events: busy[9]=1, same cycle issue 9 and write 9 -> busy[9] stays 1; with flush also asserted -> busy_vec 0, register 9 holds written value.
REQ-040 SHALL check multi-write priority (NWR=2): both ports write addr 3 with 0x1 / 0x2 -> bypass and stored value 0x2.
